// File: rtl/ahb_slave_port_mux_pkg.sv
// Shared AHB types and helpers for the slave-port multiplexer and its watchdog.
package ahb_slave_port_mux_pkg;

  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_type;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} hresp_type;
  typedef enum logic [2:0] {
    SINGLE = 3'd0, INCR = 3'd1, WRAP4 = 3'd2, INCR4 = 3'd3,
    WRAP8 = 3'd4, INCR8 = 3'd5, WRAP16 = 3'd6, INCR16 = 3'd7
  } hburst_type;
  typedef enum logic [1:0] {DP_IDLE, DP_ACTIVE, DP_ERR1, DP_ERR2} dp_state_t;

  localparam int ONEHOT_MAX = 32;
  localparam int IDX_MAX_W  = 5;

  // Callers zero-extend their grant vector and truncate the result to their own index width.
  function automatic logic [IDX_MAX_W-1:0] onehot_to_idx(input logic [ONEHOT_MAX-1:0] v);
    logic [IDX_MAX_W-1:0] idx;
    idx = '0;
    for (int i = ONEHOT_MAX - 1; i >= 0; i--) begin
      if (v[i]) idx = IDX_MAX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ahb_slave_port_mux_watchdog.sv
// Stall watchdog: counts slave wait states in DP_ACTIVE and sequences the two-cycle ERROR reply.
module ahb_slave_port_watchdog
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic      hclk,
  input  logic      hreset,
  input  dp_state_t i_state,
  input  logic      i_hreadyout,
  output logic      o_override,
  output dp_state_t o_next
);

  logic [7:0] r_cnt;
  logic       w_stall;
  logic       w_expire;

  assign w_stall  = (i_state == DP_ACTIVE) && !i_hreadyout;
  assign w_expire = w_stall && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_cnt <= '0;
    end else if (w_stall && !w_expire) begin
      r_cnt <= r_cnt + 8'd1;
    end else begin
      r_cnt <= '0;
    end
  end

  always_comb begin
    o_override = 1'b0;
    o_next     = DP_IDLE;
    case (i_state)
      DP_ACTIVE: if (w_expire) begin o_override = 1'b1; o_next = DP_ERR1; end
      DP_ERR1:   begin o_override = 1'b1; o_next = DP_ERR2; end
      DP_ERR2:   begin o_override = 1'b1; o_next = DP_IDLE; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/ahb_slave_port_mux.sv
// AHB slave-port address/data mux driven by a one-hot arbiter grant.
// Optional stall watchdog enabled by defining AHB_SLV_MUX_TIMEOUT_EN.
module ahb_slave_port_mux
  import ahb_slave_port_mux_pkg::*;
#(
  parameter int MASTER_NUM     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic [MASTER_NUM-1:0] hgrant,
  input  logic [ADDR_W-1:0]     haddr_m  [MASTER_NUM],
  input  htrans_type            htrans_m [MASTER_NUM],
  input  logic                  hwrite_m [MASTER_NUM],
  input  logic [2:0]            hsize_m  [MASTER_NUM],
  input  hburst_type            hburst_m [MASTER_NUM],
  input  logic [DATA_W-1:0]     hwdata_m [MASTER_NUM],
  output logic [ADDR_W-1:0]     haddr_s,
  output htrans_type            htrans_s,
  output logic                  hwrite_s,
  output logic [2:0]            hsize_s,
  output hburst_type            hburst_s,
  output logic [DATA_W-1:0]     hwdata_s,
  output logic                  hsel_s,
  input  logic [DATA_W-1:0]     hrdata_s,
  input  logic                  hreadyout_s,
  input  hresp_type             hresp_s,
  output logic [DATA_W-1:0]     hrdata,
  output logic [MASTER_NUM-1:0] hready_m,
  output hresp_type             hresp_m  [MASTER_NUM],
  output logic                  hwait,
  output logic                  grant_err,
  output dp_state_t             o_dbg_state
);

  localparam int IDX_W = (MASTER_NUM > 1) ? $clog2(MASTER_NUM) : 1;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  dp_state_t        r_state;
  logic [IDX_W-1:0] r_dp_idx;
  logic             r_dp_valid;
  logic             r_grant_err;

  logic [IDX_W-1:0] w_owner;
  logic             w_any;
  logic             w_multi;
  logic             w_err_state;
  logic             w_hready_int;
  logic             w_addr_xfer;
  hresp_type        w_resp_eff;
  logic             w_wd_override;
  dp_state_t        w_wd_next;

  assign w_any       = |hgrant;
  assign w_multi     = |(hgrant & (hgrant - MASTER_NUM'(1)));
  assign w_owner     = IDX_W'(onehot_to_idx(ONEHOT_MAX'(hgrant)));
  assign w_err_state = (r_state == DP_ERR1) || (r_state == DP_ERR2);

  // The slave is deselected while the watchdog answers on its behalf.
  always_comb begin
    haddr_s  = '0;
    htrans_s = IDLE;
    hwrite_s = 1'b0;
    hsize_s  = '0;
    hburst_s = SINGLE;
    hsel_s   = 1'b0;
    if (w_any && !w_err_state) begin
      hsel_s   = 1'b1;
      haddr_s  = haddr_m[w_owner];
      htrans_s = htrans_m[w_owner];
      hwrite_s = hwrite_m[w_owner];
      hsize_s  = hsize_m[w_owner];
      hburst_s = hburst_m[w_owner];
    end
  end

  assign w_addr_xfer = hsel_s && ((htrans_s == NONSEQ) || (htrans_s == SEQ));

  always_comb begin
    case (r_state)
      DP_ERR1: w_hready_int = 1'b0;
      DP_ERR2: w_hready_int = 1'b1;
      default: w_hready_int = hreadyout_s;
    endcase
  end

  assign w_resp_eff = w_err_state ? ERROR : hresp_s;
  assign hwdata_s   = hwdata_m[r_dp_idx];
  assign hrdata     = hrdata_s;
  assign hready_m   = {MASTER_NUM{w_hready_int}};
  assign hwait      = r_dp_valid && !w_hready_int;
  assign grant_err  = r_grant_err;
  assign o_dbg_state = r_state;

  always_comb begin
    for (int i = 0; i < MASTER_NUM; i++) begin
      hresp_m[i] = (r_dp_valid && (r_dp_idx == IDX_W'(i))) ? w_resp_eff : OKAY;
    end
  end

`ifdef AHB_SLV_MUX_TIMEOUT_EN
  ahb_slave_port_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .hclk       (hclk),
    .hreset     (hreset),
    .i_state    (r_state),
    .i_hreadyout(hreadyout_s),
    .o_override (w_wd_override),
    .o_next     (w_wd_next)
  );
`else
  assign w_wd_override = 1'b0;
  assign w_wd_next     = DP_IDLE;
`endif

  // Data-phase owner advances on every accepted address phase, so back-to-back transfers need no bubble.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      r_state     <= DP_IDLE;
      r_dp_idx    <= '0;
      r_dp_valid  <= 1'b0;
      r_grant_err <= 1'b0;
    end else begin
      if (w_multi) r_grant_err <= 1'b1;
      if (w_hready_int) begin
        r_dp_idx   <= w_owner;
        r_dp_valid <= w_addr_xfer;
      end
      if (w_wd_override) begin
        r_state <= w_wd_next;
      end else begin
        case (r_state)
          DP_IDLE:   if (w_hready_int && w_addr_xfer) r_state <= DP_ACTIVE;
          DP_ACTIVE: if (w_hready_int && !w_addr_xfer) r_state <= DP_IDLE;
          default:   r_state <= DP_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ahb_slave_port_mux.sv
// Directed-vector bench for ahb_slave_port_mux; covers the watchdog when AHB_SLV_MUX_TIMEOUT_EN is defined.
module tb_ahb_slave_port_mux;
  import ahb_slave_port_mux_pkg::*;

  localparam int M = 4;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [M-1:0] hgrant;
  logic [31:0] haddr_m  [M];
  htrans_type  htrans_m [M];
  logic        hwrite_m [M];
  logic [2:0]  hsize_m  [M];
  hburst_type  hburst_m [M];
  logic [31:0] hwdata_m [M];
  logic [31:0] haddr_s;
  htrans_type  htrans_s;
  logic        hwrite_s;
  logic [2:0]  hsize_s;
  hburst_type  hburst_s;
  logic [31:0] hwdata_s;
  logic        hsel_s;
  logic [31:0] hrdata_s;
  logic        hreadyout_s;
  hresp_type   hresp_s;
  logic [31:0] hrdata;
  logic [M-1:0] hready_m;
  hresp_type   hresp_m [M];
  logic        hwait;
  logic        grant_err;
  dp_state_t   dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  ahb_slave_port_mux #(
    .MASTER_NUM(M), .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)
  ) dut (
    .hclk(hclk), .hreset(hreset), .hgrant(hgrant),
    .haddr_m(haddr_m), .htrans_m(htrans_m), .hwrite_m(hwrite_m),
    .hsize_m(hsize_m), .hburst_m(hburst_m), .hwdata_m(hwdata_m),
    .haddr_s(haddr_s), .htrans_s(htrans_s), .hwrite_s(hwrite_s),
    .hsize_s(hsize_s), .hburst_s(hburst_s), .hwdata_s(hwdata_s),
    .hsel_s(hsel_s), .hrdata_s(hrdata_s), .hreadyout_s(hreadyout_s),
    .hresp_s(hresp_s), .hrdata(hrdata), .hready_m(hready_m),
    .hresp_m(hresp_m), .hwait(hwait), .grant_err(grant_err),
    .o_dbg_state(dbg_state)
  );

  // Clock / reset
  always #10 hclk = ~hclk;

  // Driver tasks
  task automatic drive(input logic [M-1:0] g, input htrans_type tr, input logic wr,
                       input logic rdy, input hresp_type rsp, input logic [31:0] rd);
    hgrant = g;
    for (int i = 0; i < M; i++) begin
      htrans_m[i] = tr;
      hwrite_m[i] = wr;
    end
    hreadyout_s = rdy;
    hresp_s     = rsp;
    hrdata_s    = rd;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [M-1:0] resp_bits();
    logic [M-1:0] r;
    for (int i = 0; i < M; i++) r[i] = (hresp_m[i] == ERROR);
    return r;
  endfunction

  typedef struct {
    logic [3:0]  g;
    htrans_type  tr;
    logic        wr;
    logic        rdy;
    hresp_type   rsp;
    logic [31:0] e_addr;
    htrans_type  e_tr;
    logic        e_sel;
    logic [1:0]  e_idx;
    logic        e_hready;
    logic [3:0]  e_resp;
    logic        e_wait;
    logic        e_gerr;
    dp_state_t   e_st;
  } vec_t;

  vec_t vecs [17];

  initial begin
    logic [2:0]  exp_size;
    logic [31:0] exp_wd;

    // Master i sits at 0x100*(i+1) with distinct size/burst/data so the selected source is visible.
    for (int i = 0; i < M; i++) begin
      haddr_m[i]  = 32'h100 * (i + 1);
      hsize_m[i]  = 3'(i);
      hburst_m[i] = hburst_type'(i + 1);
      hwdata_m[i] = 32'hD000_0000 + 32'(i);
    end

    //             g       tr      wr    rdy   rsp  | addr     tr      sel   idx   rdy   resp     wait  gerr  state
    vecs[0]  = '{4'b0001, NONSEQ, 1'b1, 1'b1, OKAY,  32'h100, NONSEQ, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[1]  = '{4'b0100, NONSEQ, 1'b1, 1'b1, OKAY,  32'h300, NONSEQ, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_ACTIVE};
    vecs[2]  = '{4'b0000, IDLE,   1'b0, 1'b1, OKAY,  32'h000, IDLE,   1'b0, 2'd2, 1'b1, 4'b0000, 1'b0, 1'b0, DP_ACTIVE};
    vecs[3]  = '{4'b0010, NONSEQ, 1'b0, 1'b1, OKAY,  32'h200, NONSEQ, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[4]  = '{4'b0010, IDLE,   1'b0, 1'b0, OKAY,  32'h200, IDLE,   1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 1'b0, DP_ACTIVE};
    vecs[5]  = '{4'b0010, IDLE,   1'b0, 1'b0, OKAY,  32'h200, IDLE,   1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 1'b0, DP_ACTIVE};
    vecs[6]  = '{4'b0010, IDLE,   1'b0, 1'b0, OKAY,  32'h200, IDLE,   1'b1, 2'd1, 1'b0, 4'b0000, 1'b1, 1'b0, DP_ACTIVE};
    vecs[7]  = '{4'b0010, IDLE,   1'b0, 1'b1, OKAY,  32'h200, IDLE,   1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0, DP_ACTIVE};
    vecs[8]  = '{4'b1000, NONSEQ, 1'b0, 1'b1, OKAY,  32'h400, NONSEQ, 1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[9]  = '{4'b1000, IDLE,   1'b0, 1'b0, ERROR, 32'h400, IDLE,   1'b1, 2'd3, 1'b0, 4'b1000, 1'b1, 1'b0, DP_ACTIVE};
    vecs[10] = '{4'b0000, IDLE,   1'b0, 1'b1, ERROR, 32'h000, IDLE,   1'b0, 2'd3, 1'b1, 4'b1000, 1'b0, 1'b0, DP_ACTIVE};
    vecs[11] = '{4'b0000, IDLE,   1'b0, 1'b1, ERROR, 32'h000, IDLE,   1'b0, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[12] = '{4'b0001, BUSY,   1'b0, 1'b1, OKAY,  32'h100, BUSY,   1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[13] = '{4'b0001, IDLE,   1'b0, 1'b0, ERROR, 32'h100, IDLE,   1'b1, 2'd0, 1'b0, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[14] = '{4'b0110, NONSEQ, 1'b1, 1'b1, OKAY,  32'h200, NONSEQ, 1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b0, DP_IDLE};
    vecs[15] = '{4'b0000, IDLE,   1'b0, 1'b1, OKAY,  32'h000, IDLE,   1'b0, 2'd1, 1'b1, 4'b0000, 1'b0, 1'b1, DP_ACTIVE};
    vecs[16] = '{4'b0001, IDLE,   1'b0, 1'b1, OKAY,  32'h100, IDLE,   1'b1, 2'd0, 1'b1, 4'b0000, 1'b0, 1'b1, DP_IDLE};

    // Reset state
    hreset = 1'b1;
    drive(4'b0000, IDLE, 1'b0, 1'b1, OKAY, 32'h0);
    repeat (2) @(negedge hclk);
    #1;
    check("rst_hwait", hwait, 1'b0);
    check("rst_hresp", resp_bits(), 4'b0000);
    check("rst_hready_hi", hready_m, 4'b1111);
    check("rst_grant_err", grant_err, 1'b0);
    check("rst_state", dbg_state, DP_IDLE);
    check("rst_hsel", hsel_s, 1'b0);
    hreadyout_s = 1'b0;
    #1;
    check("rst_hready_lo", hready_m, 4'b0000);
    @(negedge hclk);
    hreset = 1'b0;

    // Table-driven cycles: inputs applied after the falling edge, outputs sampled 1 ns later.
    for (int k = 0; k < 17; k++) begin
      @(negedge hclk);
      drive(vecs[k].g, vecs[k].tr, vecs[k].wr, vecs[k].rdy, vecs[k].rsp, 32'h5A00_0000 + 32'(k));
      #1;
      exp_size = vecs[k].e_sel ? 3'((vecs[k].e_addr >> 8) - 1) : 3'd0;
      exp_q.push_back(32'hD000_0000 + 32'(vecs[k].e_idx));
      exp_wd = exp_q.pop_front();
      check($sformatf("v%0d_haddr", k), haddr_s, vecs[k].e_addr);
      check($sformatf("v%0d_htrans", k), htrans_s, vecs[k].e_tr);
      check($sformatf("v%0d_hsel", k), hsel_s, vecs[k].e_sel);
      check($sformatf("v%0d_hwrite", k), hwrite_s, vecs[k].wr & vecs[k].e_sel);
      check($sformatf("v%0d_hsize", k), hsize_s, exp_size);
      check($sformatf("v%0d_hburst", k), hburst_s, vecs[k].e_sel ? 3'(exp_size + 3'd1) : 3'd0);
      check($sformatf("v%0d_hwdata", k), hwdata_s, exp_wd);
      check($sformatf("v%0d_hrdata", k), hrdata, 32'h5A00_0000 + 32'(k));
      check($sformatf("v%0d_hready", k), hready_m, {M{vecs[k].e_hready}});
      check($sformatf("v%0d_hresp", k), resp_bits(), vecs[k].e_resp);
      check($sformatf("v%0d_hwait", k), hwait, vecs[k].e_wait);
      check($sformatf("v%0d_grant_err", k), grant_err, vecs[k].e_gerr);
      check($sformatf("v%0d_state", k), dbg_state, vecs[k].e_st);
    end

    // Reset asserted mid-transfer while the slave is stalling.
    @(negedge hclk);
    drive(4'b0001, NONSEQ, 1'b1, 1'b1, OKAY, 32'h0);
    @(negedge hclk);
    drive(4'b0001, IDLE, 1'b0, 1'b0, OKAY, 32'h0);
    #1;
    check("mid_pre_hwait", hwait, 1'b1);
    check("mid_pre_state", dbg_state, DP_ACTIVE);
    #2;
    hreset = 1'b1;
    #1;
    check("mid_hwait", hwait, 1'b0);
    check("mid_state", dbg_state, DP_IDLE);
    check("mid_grant_err", grant_err, 1'b0);
    check("mid_hresp", resp_bits(), 4'b0000);
    check("mid_hready_lo", hready_m, 4'b0000);
    check("mid_hwdata", hwdata_s, 32'hD000_0000);
    hreadyout_s = 1'b1;
    #1;
    check("mid_hready_hi", hready_m, 4'b1111);
    @(negedge hclk);
    hreset = 1'b0;

    // Slave stalls indefinitely after an m0 write.
    @(negedge hclk);
    drive(4'b0001, NONSEQ, 1'b1, 1'b1, OKAY, 32'h0);
`ifdef AHB_SLV_MUX_TIMEOUT_EN
    for (int c = 1; c <= 4; c++) begin
      @(negedge hclk);
      drive(4'b0001, NONSEQ, 1'b1, 1'b0, OKAY, 32'h0);
      #1;
      check($sformatf("to_c%0d_state", c), dbg_state, DP_ACTIVE);
      check($sformatf("to_c%0d_hwait", c), hwait, 1'b1);
    end
    @(negedge hclk);
    #1;
    check("err1_state", dbg_state, DP_ERR1);
    check("err1_hsel", hsel_s, 1'b0);
    check("err1_htrans", htrans_s, IDLE);
    check("err1_hready", hready_m, 4'b0000);
    check("err1_hresp", resp_bits(), 4'b0001);
    check("err1_hwait", hwait, 1'b1);
    @(negedge hclk);
    #1;
    check("err2_state", dbg_state, DP_ERR2);
    check("err2_hready", hready_m, 4'b1111);
    check("err2_hresp", resp_bits(), 4'b0001);
    check("err2_hwait", hwait, 1'b0);
    @(negedge hclk);
    #1;
    check("post_err_state", dbg_state, DP_IDLE);
    check("post_err_hresp", resp_bits(), 4'b0000);
    check("post_err_hwait", hwait, 1'b0);
`else
    for (int c = 1; c <= 20; c++) begin
      @(negedge hclk);
      drive(4'b0001, NONSEQ, 1'b1, 1'b0, OKAY, 32'h0);
      #1;
      check($sformatf("stall_c%0d_state", c), dbg_state, DP_ACTIVE);
      check($sformatf("stall_c%0d_hwait", c), hwait, 1'b1);
    end
    check("stall_hready", hready_m, 4'b0000);
    check("stall_hresp", resp_bits(), 4'b0000);
    @(negedge hclk);
    drive(4'b0000, IDLE, 1'b0, 1'b1, OKAY, 32'h0);
    #1;
    check("stall_end_hwait", hwait, 1'b0);
    check("stall_end_hready", hready_m, 4'b1111);
    @(negedge hclk);
    #1;
    check("stall_end_state", dbg_state, DP_IDLE);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
